// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM states, PC step
// and the width of a buffered {PC, instruction} entry.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Each fetch reads two ROM bytes, so the PC always advances by two.
    localparam int unsigned PC_STEP = 2;

    // Buffer entry layout is {pc, instr}; instr is two ROM bytes wide.
    function automatic int unsigned entry_width(input int unsigned addr_bits,
                                                input int unsigned width);
        return addr_bits + 2 * width;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer of {PC, instr} entries; flush wins over push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage driving the dual-byte program ROM and buffering tagged words for decode.
// Optional perf counters are built only when IFETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FetchEnable,
    input  logic                   BranchTaken,
    input  logic [ADDR_BITS-1:0]   BranchTarget,
    output logic                   ROMEnable,
    output logic [ADDR_BITS-1:0]   Address,
    input  logic [2*WIDTH-1:0]     ROMData,
    output logic                   InstrValid,
    input  logic                   InstrReady,
    output logic [2*WIDTH-1:0]     Instr,
    output logic [ADDR_BITS-1:0]   InstrPC,
    output logic [15:0]            FetchCount,
    output logic [15:0]            StallCount
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned EW = entry_width(ADDR_BITS, WIDTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_BITS-1:0] PC_RST = ADDR_BITS'(RESET_PC);

    state_e               state_q;
    logic [ADDR_BITS-1:0] pc_q;
    logic [ADDR_BITS-1:0] tag_q;
    logic                 inflight_q;

    logic [EW-1:0]        head;
    logic [CW-1:0]        count;
    logic [CW:0]          occupancy;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 room;
    logic                 issue;

    assign pop       = !empty && InstrReady;
    // The in-flight read already owns a buffer slot, so it counts toward occupancy.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
    assign room      = !full && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign issue     = (state_q == S_RUN) && !BranchTaken && (room || pop);

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (BranchTaken),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  ({tag_q, ROMData}),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE:  if (FetchEnable) state_q <= S_RUN;
                S_RUN:   if (!FetchEnable) state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (FetchEnable) begin
                        state_q <= S_RUN;
                    end else if (!inflight_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (BranchTaken) begin
                pc_q       <= BranchTarget & ~ADDR_BITS'(1);
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    pc_q  <= pc_q + ADDR_BITS'(PC_STEP);
                    tag_q <= pc_q;
                end
            end
        end
    end

    assign ROMEnable  = issue;
    assign Address    = pc_q;
    assign InstrValid = !empty;
    assign Instr      = empty ? '0 : head[IW-1:0];
    assign InstrPC    = empty ? '0 : head[EW-1:IW];

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        stall;

    assign stall = (state_q == S_RUN) && !BranchTaken && !(room || pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && !BranchTaken && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    assign FetchCount = '0;
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural dual-byte ROM.
module tb_instr_fetch_unit;

    localparam int AB    = 4;
    localparam int DEPTH = 2;
    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FetchEnable = 1'b0;
    logic          BranchTaken = 1'b0;
    logic [AB-1:0] BranchTarget = '0;
    logic          ROMEnable;
    logic [AB-1:0] Address;
    logic [15:0]   ROMData;
    logic          InstrValid;
    logic          InstrReady = 1'b0;
    logic [15:0]   Instr;
    logic [AB-1:0] InstrPC;
    logic [15:0]   FetchCount;
    logic [15:0]   StallCount;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .ADDR_BITS  (AB),
        .WIDTH      (8),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (0)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FetchEnable  (FetchEnable),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ROMEnable    (ROMEnable),
        .Address      (Address),
        .ROMData      (ROMData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .FetchCount   (FetchCount),
        .StallCount   (StallCount)
    );

    always #5 CLK = ~CLK;

    // Program ROM: byte i holds 0x10+i; registered read of {byte[A+1], byte[A]}.
    logic [7:0] rom_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'(8'h10 + i);
    end
    always_ff @(posedge CLK) begin
        ROMData <= ROMEnable ? {rom_mem[Address + 4'd1], rom_mem[Address]} : 16'h0000;
    end

    typedef struct {int pc; int instr;} ent_t;
    typedef struct {int cyc; int pc; int instr;} out_t;
    typedef struct {bit en; int addr; int fc; int sc;} cyc_t;

    ent_t m_q[$];
    out_t out_q[$];
    cyc_t cyc_q[$];

    int m_mode, m_pc, m_tag, m_inflight, m_fc, m_sc;
    int drv_cyc = 0;

    function automatic int rom_word(input int pc);
        return ((16 + pc + 1) << 8) | (16 + pc);
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_mode = MD_IDLE;
        m_pc = 0;
        m_tag = 0;
        m_inflight = 0;
        m_fc = 0;
        m_sc = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model through that cycle.
    task automatic cycle(input bit fe, input bit rdy, input bit br, input int tgt, input bit rst);
        bit valid, pop, room, issue, stall;
        int nxt;
        @(negedge CLK);
        FetchEnable  = fe;
        InstrReady   = rdy;
        BranchTaken  = br;
        BranchTarget = AB'(tgt);
        RST          = rst;

        valid = (m_q.size() != 0);
        if (valid) out_q.push_back('{drv_cyc, m_q[0].pc, m_q[0].instr});
        pop   = valid && rdy && !br;
        room  = (m_q.size() + m_inflight) < DEPTH;
        issue = (m_mode == MD_RUN) && !br && (room || pop);
        stall = (m_mode == MD_RUN) && !br && !room && !pop;
        cyc_q.push_back('{issue, m_pc, m_fc, m_sc});

        if (rst) begin
            model_reset();
        end else begin
            nxt = m_mode;
            if (m_mode == MD_IDLE && fe) nxt = MD_RUN;
            else if (m_mode == MD_RUN && !fe) nxt = MD_DRAIN;
            else if (m_mode == MD_DRAIN) nxt = fe ? MD_RUN : (m_inflight == 0 ? MD_IDLE : MD_DRAIN);
`ifdef IFETCH_PERF_CNT_EN
            if (pop && m_fc < 65535) m_fc++;
            if (stall && m_sc < 65535) m_sc++;
`endif
            if (br) begin
                m_q.delete();
                m_inflight = 0;
                m_pc = (tgt % 16) & ~1;
            end else begin
                if (pop) m_q.delete(0);
                if (m_inflight != 0) m_q.push_back('{m_tag, rom_word(m_tag)});
                m_inflight = issue ? 1 : 0;
                if (issue) begin
                    m_tag = m_pc;
                    m_pc = (m_pc + 2) % 16;
                end
            end
            m_mode = nxt;
        end
        drv_cyc++;
    endtask

    // Monitor: per-cycle ROM-side checks and in-order checks of presented instructions.
    int mon_cyc = 0;
    initial begin
        cyc_t cr;
        out_t o;
        forever begin
            @(negedge CLK);
            #1;
            if (cyc_q.size() > 0) begin
                cr = cyc_q.pop_front();
                check("rom_enable", 32'(ROMEnable), 32'(cr.en));
                check("address", 32'(Address), cr.addr);
                check("fetch_count", 32'(FetchCount), cr.fc);
                check("stall_count", 32'(StallCount), cr.sc);
            end
            while (out_q.size() > 0 && out_q[0].cyc < mon_cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_instr: cycle %0d InstrValid low, expected pc=0x%0h instr=0x%0h",
                         out_q[0].cyc, out_q[0].pc, out_q[0].instr);
                out_q.delete(0);
            end
            if (InstrValid) begin
                if (out_q.size() == 0 || out_q[0].cyc != mon_cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: cycle %0d pc=0x%0h instr=0x%0h, expected none",
                             mon_cyc, InstrPC, Instr);
                end else begin
                    o = out_q.pop_front();
                    check("instr_pc", 32'(InstrPC), o.pc);
                    check("instr", 32'(Instr), o.instr);
                end
            end
            mon_cyc++;
        end
    end

    initial begin
        model_reset();
        // Reset state
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        #2;
        check("rst_rom_enable", 32'(ROMEnable), 0);
        check("rst_address", 32'(Address), 0);
        check("rst_valid", 32'(InstrValid), 0);
        check("rst_instr", 32'(Instr), 0);
        check("rst_instr_pc", 32'(InstrPC), 0);
        check("rst_fetch_count", 32'(FetchCount), 0);
        check("rst_stall_count", 32'(StallCount), 0);

        // Streaming through the PC wrap
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 0);
        // Backpressure then release
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
        #2 check("bp_valid_held", 32'(InstrValid), 1);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);

        // Redirect to 0x9 while buffer slots are all committed
        cycle(1, 0, 1, 9, 0);
        cycle(1, 1, 0, 0, 0);
        #2;
        check("br_valid_flushed", 32'(InstrValid), 0);
        check("br_address", 32'(Address), 8);
        check("br_rom_enable", 32'(ROMEnable), 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        #2;
        check("br_target_instr", 32'(Instr), 32'h1918);
        check("br_target_pc", 32'(InstrPC), 8);

        // Redirect on a pop cycle
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 4, 0);
        cycle(1, 1, 0, 0, 0);
        #2;
        check("brpop_valid", 32'(InstrValid), 0);
        check("brpop_address", 32'(Address), 4);

        // FetchEnable dropped: drain then idle
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        #2;
        check("drain_rom_enable", 32'(ROMEnable), 0);
        check("drain_valid", 32'(InstrValid), 0);

        // RST pulsed mid-stream
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        #2;
        check("midrst_valid", 32'(InstrValid), 0);
        check("midrst_address", 32'(Address), 0);

        // Pops interleaved with full-buffer stalls
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 99) == 0);
        end

        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
        #3;
        check("leftover_instr", 32'(out_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
